pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage register that succeeds the fixed PC/instruction stage latch between pipeline stages. It carries a `DATA_W`-bit payload with valid/ready handshakes on both sides and supports the existing freeze (stall) and flush controls. An optional two-entry skid buffer decouples `in_ready` from `out_ready`, and optional performance counters can be compiled in.

---
 rtl/pipe_stage_buf.sv | 100 ++++++++++
 tb/tb_pipe_stage_buf.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready on both sides, freeze/flush control and an
// optional two-entry skid buffer (SKID=1). Define PIPE_STAGE_BUF_PERF_EN to add stall/freeze counters.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
`endif
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic              push, pop;

  assign out_valid = m_valid && !freeze;
  assign out_data  = m_data;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  // Main register: refilled from the skid entry first so ordering stays FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (!freeze) begin
      if (pop && s_valid) begin
        m_data <= s_data;
      end else if ((!m_valid || pop) && push) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // in_ready depends only on registered state, breaking the out_ready->in_ready path.
      assign in_ready = !freeze && !flush && !s_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s_valid <= 1'b0;
          s_data  <= '0;
        end else if (flush) begin
          s_valid <= 1'b0;
          s_data  <= '0;
        end else if (!freeze) begin
          if (pop && s_valid) begin
            if (push) s_data <= in_data;
            else      s_valid <= 1'b0;
          end else if (push && m_valid && !pop) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
          end
        end
      end
    end else begin : g_noskid
      assign s_valid  = 1'b0;
      assign s_data   = '0;
      assign in_ready = !freeze && !flush && (!m_valid || out_ready);
    end
  endgenerate

`ifdef PIPE_STAGE_BUF_PERF_EN
  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (m_valid && !freeze && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (freeze && (freeze_cnt != '1))
        freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 and a SKID=0 instance share stimulus, each with its own
// scoreboard queue, plus directed checks of occupancy, ready/valid and control priority.
module tb_pipe_stage_buf;
  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, out_ready, freeze, flush;
  logic [DW-1:0] in_data;
  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CW-1:0] sc1, fc1, sc0, fc0;
  int            e_sc1, e_fc1, e_sc0, e_fc0;
`endif

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .freeze(freeze), .flush(flush), .occupancy(occ1)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(sc1), .freeze_cnt(fc1)
`endif
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .freeze(freeze), .flush(flush), .occupancy(occ0)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(sc0), .freeze_cnt(fc0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so negedge sees the handshake of that edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("sb1_underflow", out_data1, 64'hdead);
        else                chk("sb1_data", out_data1, q1.pop_front());
      end
      if (in_valid && in_ready1) q1.push_back(in_data);
      if (flush) q1.delete();
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("sb0_underflow", out_data0, 64'hdead);
        else                chk("sb0_data", out_data0, q0.pop_front());
      end
      if (in_valid && in_ready0) q0.push_back(in_data);
      if (flush) q0.delete();
`ifdef PIPE_STAGE_BUF_PERF_EN
      if (out_valid1 && !out_ready && e_sc1 < CMAX) e_sc1++;
      if (out_valid0 && !out_ready && e_sc0 < CMAX) e_sc0++;
      if (freeze && e_fc1 < CMAX) e_fc1++;
      if (freeze && e_fc0 < CMAX) e_fc0++;
`endif
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0; in_data = '0;
`ifdef PIPE_STAGE_BUF_PERF_EN
    e_sc1 = 0; e_fc1 = 0; e_sc0 = 0; e_fc0 = 0;
`endif
    #12 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_data", out_data1, 0);
    chk("rst_occ", occ1, 0);
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_in_ready0", in_ready0, 1);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("rst_stall_cnt", sc1, 0);
    chk("rst_freeze_cnt", fc1, 0);
`endif

    // Back-to-back streaming
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h11 + i);
      cyc();
      chk("strm_data", out_data1, 8'h11 + i);
      chk("strm_valid", out_valid1, 1);
      chk("strm_occ", occ1, 1);
      chk("strm_data0", out_data0, 8'h11 + i);
    end
    in_valid = 1'b0;
    cyc();
    chk("strm_drain_occ", occ1, 0);

    // Skid back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA1;
    cyc();
    chk("skid_occ1", occ1, 1);
    in_data = 16'hA2;
    cyc();
    chk("skid_occ2", occ1, 2);
    chk("skid_occ0", occ0, 1);
    in_data = 16'hA3;
    chk("skid_in_ready", in_ready1, 0);
    chk("skid_in_ready0", in_ready0, 0);
    chk("skid_head", out_data1, 16'hA1);
    cyc();
    chk("skid_hold_occ", occ1, 2);
    out_ready = 1'b1;
    cyc();
    chk("skid_out_a2", out_data1, 16'hA2);
    chk("skid_occ_after", occ1, 1);
    cyc();
    chk("skid_out_a3", out_data1, 16'hA3);
    in_valid = 1'b0;
    cyc();
    chk("skid_empty", occ1, 0);
    chk("skid_empty0", occ0, 0);

    // Freeze
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hB0;
    cyc();
    in_data = 16'hB1; freeze = 1'b1; out_ready = 1'b1;
    #1;
    chk("frz_out_valid", out_valid1, 0);
    chk("frz_in_ready", in_ready1, 0);
    chk("frz_in_ready0", in_ready0, 0);
    repeat (3) cyc();
    chk("frz_occ", occ1, 1);
    chk("frz_data", out_data1, 16'hB0);
    freeze = 1'b0;
    #1;
    chk("frz_rel_valid", out_valid1, 1);
    chk("frz_rel_data", out_data1, 16'hB0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("frz_cnt", fc1, 3);
`endif
    cyc();
    chk("frz_next", out_data1, 16'hB1);
    in_valid = 1'b0;
    cyc();

    // Flush beats freeze and push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hD1;
    cyc();
    in_data = 16'hD2;
    cyc();
    chk("fl_pre_occ", occ1, 2);
    flush = 1'b1; freeze = 1'b1; in_data = 16'hD3;
    #1;
    chk("fl_in_ready", in_ready1, 0);
    chk("fl_in_ready0", in_ready0, 0);
    cyc();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_occ", occ1, 0);
    chk("fl_data", out_data1, 0);
    chk("fl_valid", out_valid1, 0);
    chk("fl_occ0", occ0, 0);
    cyc();

    // SKID=0 same-edge replace
    in_valid = 1'b1; in_data = 16'hC0;
    cyc();
    out_ready = 1'b1; in_data = 16'hC1;
    #1;
    chk("pt_in_ready0", in_ready0, 1);
    cyc();
    chk("pt_data0", out_data0, 16'hC1);
    chk("pt_occ0", occ0, 1);
    in_valid = 1'b0;
    cyc();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      freeze    = 1'($urandom_range(0, 9) == 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      cyc();
    end
    in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_occ", occ1, 0);

`ifdef PIPE_STAGE_BUF_PERF_EN
    // Hold an entry under back-pressure long enough to saturate the stall counter
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hE0;
    cyc();
    in_valid = 1'b0;
    repeat (CMAX + 10) cyc();
    chk("sat_stall", sc1, CMAX);
    chk("model_stall1", sc1, e_sc1);
    chk("model_stall0", sc0, e_sc0);
    chk("model_frz1", fc1, e_fc1);
    chk("model_frz0", fc0, e_fc0);
`endif

    // Async reset between edges with two entries held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hF1;
    cyc();
    in_data = 16'hF2;
    cyc();
    in_valid = 1'b0;
    chk("ar_pre_occ", occ1, 2);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid1, 0);
    chk("ar_occ", occ1, 0);
    chk("ar_occ0", occ0, 0);
    chk("ar_data", out_data1, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("ar_stall_cnt", sc1, 0);
    chk("ar_freeze_cnt", fc1, 0);
`endif
    q1.delete(); q0.delete();
    #20;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
